contador_modn: RTL and testbench

//  Parametrised modulo-N counter; next generation of the mod-10 digit counter used in the

---
 rtl/contador_modn.sv | 103 ++++++++++
 tb/tb_contador_modn.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_modn.sv
// Modulo-N up/down digit counter with cascade carry-in, clamped load and terminal-count carry out.
// Optional single-shot saturation (no wrap, sticky fim flag) when CONTADOR_SATURA_EN is defined.
module contador_modn #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             en,
    input  logic             cin,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero,
    output logic             fim
);

    localparam int             LP_M1   = MODULUS - 1;
    localparam logic [WIDTH:0] LP_MOD  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0] LP_LAST = LP_M1[WIDTH:0];
    localparam logic [WIDTH:0] LP_ONE  = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_step;
    logic             w_at_term;
    logic [WIDTH-1:0] w_up_nxt;
    logic [WIDTH-1:0] w_dn_nxt;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    // Arithmetic is one bit wider so the wrap/clamp compares see the true value;
    // any out-of-range count maps back to 0 (up) or MODULUS-1 (down) on the next step.
    always_comb begin
        w_cnt_x    = {1'b0, r_count};
        w_inc      = w_cnt_x + LP_ONE;
        w_dec      = w_cnt_x - LP_ONE;
        w_step     = en & cin & ~load;
        w_at_term  = up ? (w_cnt_x == LP_LAST) : (r_count == '0);
        w_up_nxt   = (w_inc >= LP_MOD) ? '0 : w_inc[WIDTH-1:0];
        w_dn_nxt   = ((w_dec >= LP_MOD) || (w_cnt_x >= LP_MOD)) ? LP_LAST[WIDTH-1:0]
                                                                 : w_dec[WIDTH-1:0];
        w_step_val = up ? w_up_nxt : w_dn_nxt;
        w_load_val = ({1'b0, data} >= LP_MOD) ? LP_LAST[WIDTH-1:0] : data;
    end

`ifdef CONTADOR_SATURA_EN
    logic r_fim;
    logic r_tc_arm;
    logic w_nxt_term;

    always_comb begin
        w_nxt_term = up ? (w_step_val == LP_LAST[WIDTH-1:0]) : (w_step_val == '0);
    end

    // The counter parks on the terminal value; tc is armed only by the step that
    // arrives there, so a parked digit never keeps carrying into the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_fim    <= 1'b0;
            r_tc_arm <= 1'b0;
        end else if (load) begin
            r_count  <= w_load_val;
            r_fim    <= 1'b0;
            r_tc_arm <= 1'b0;
        end else if (w_step) begin
            if (w_at_term) begin
                r_fim    <= 1'b1;
                r_tc_arm <= 1'b0;
            end else begin
                r_count  <= w_step_val;
                r_tc_arm <= w_nxt_term;
            end
        end
    end

    assign tc  = w_step & r_tc_arm;
    assign fim = r_fim;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_load_val;
        end else if (w_step) begin
            r_count <= w_step_val;
        end
    end

    assign tc  = w_step & w_at_term;
    assign fim = 1'b0;
`endif

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

// File: tb/tb_contador_modn.sv
// Directed bench: mod-10 digit standalone, then cascaded with a mod-6 tens digit.
module tb_contador_modn;

    logic       clk;
    logic       reset;
    logic [3:0] data;
    logic [3:0] t_data;
    logic       load;
    logic       en;
    logic       t_en;
    logic       cin;
    logic       up;
    logic [3:0] u_count;
    logic [3:0] t_count;
    logic       u_tc;
    logic       t_tc;
    logic       u_zero;
    logic       t_zero;
    logic       u_fim;
    logic       t_fim;

    int n_cmp  = 0;
    int n_fail = 0;

    contador_modn #(.MODULUS(10), .WIDTH(4)) u_units (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .load  (load),
        .en    (en),
        .cin   (cin),
        .up    (up),
        .count (u_count),
        .tc    (u_tc),
        .zero  (u_zero),
        .fim   (u_fim)
    );

    contador_modn #(.MODULUS(6), .WIDTH(4)) u_tens (
        .clk   (clk),
        .reset (reset),
        .data  (t_data),
        .load  (load),
        .en    (t_en),
        .cin   (u_tc),
        .up    (up),
        .count (t_count),
        .tc    (t_tc),
        .zero  (t_zero),
        .fim   (t_fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_u;
        int exp_t;
        reset  = 1'b1;
        data   = 4'd0;
        t_data = 4'd0;
        load   = 1'b0;
        en     = 1'b0;
        t_en   = 1'b0;
        cin    = 1'b1;
        up     = 1'b0;

        // Test 1: asynchronous reset mid-clock, before any edge
        #3 reset = 1'b0;
        #1;
        chk("rst_count", 32'(u_count), 32'd0);
        chk("rst_zero",  32'(u_zero),  32'd1);
        chk("rst_tc",    32'(u_tc),    32'd0);
        chk("rst_fim",   32'(u_fim),   32'd0);
        chk("rst_tens",  32'(t_count), 32'd0);

        // Test 2: load 7, count down through wrap
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b1;
        data  = 4'd7;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_u = (17 - i) % 10;
            #1;
            chk("down_count", 32'(u_count), 32'(exp_u));
            chk("down_tc",    32'(u_tc),    (exp_u == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Test 3: clamped loads
        en   = 1'b0;
        load = 1'b1;
        data = 4'd12;
        @(negedge clk); #1;
        chk("clamp12", 32'(u_count), 32'd9);
        chk("load_tc", 32'(u_tc),    32'd0);
        data = 4'd0;
        @(negedge clk); #1;
        chk("load0_count", 32'(u_count), 32'd0);
        data = 4'd15;
        @(negedge clk); #1;
        chk("clamp15", 32'(u_count), 32'd9);
        chk("clamp15_zero", 32'(u_zero), 32'd0);
        data = 4'd0;
        @(negedge clk); #1;
        chk("load0_again", 32'(u_count), 32'd0);
        chk("load0_zero",  32'(u_zero),  32'd1);

        // Test 4: count up through wrap, then cin=0 holds
        data = 4'd8;
        @(negedge clk); #1;
        chk("load8", 32'(u_count), 32'd8);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #1;
        chk("up8_tc", 32'(u_tc), 32'd0);
        @(negedge clk); #1;
        chk("up9", 32'(u_count), 32'd9);
        chk("up9_tc", 32'(u_tc), 32'd1);
        @(negedge clk); #1;
        chk("up0", 32'(u_count), 32'd0);
        chk("up0_tc", 32'(u_tc), 32'd0);
        @(negedge clk); #1;
        chk("up1", 32'(u_count), 32'd1);
        cin = 1'b0;
        #1;
        chk("cin0_tc", 32'(u_tc), 32'd0);
        @(negedge clk); #1;
        chk("cin0_hold", 32'(u_count), 32'd1);
        @(negedge clk); #1;
        chk("cin0_hold2", 32'(u_count), 32'd1);

        // Test 5: load beats a terminal step
        cin  = 1'b1;
        en   = 1'b0;
        load = 1'b1;
        data = 4'd0;
        @(negedge clk); #1;
        chk("pre5_count", 32'(u_count), 32'd0);
        up   = 1'b0;
        en   = 1'b1;
        data = 4'd5;
        #1;
        chk("load_vs_term_tc", 32'(u_tc), 32'd0);
        @(negedge clk);
        load = 1'b0;
        en   = 1'b0;
        #1;
        chk("load_vs_term_cnt", 32'(u_count), 32'd5);
        chk("en0_tc", 32'(u_tc), 32'd0);
        @(negedge clk); #1;
        chk("en0_hold", 32'(u_count), 32'd5);

        // Reset asserted while counting, released at a negedge
        en = 1'b1;
        up = 1'b1;
        @(negedge clk); #1;
        chk("pre_rst_count", 32'(u_count), 32'd6);
        #1 reset = 1'b0;
        #1;
        chk("midrst_count", 32'(u_count), 32'd0);
        chk("midrst_zero",  32'(u_zero),  32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_count", 32'(u_count), 32'd0);
        @(negedge clk); #1;
        chk("rel_step", 32'(u_count), 32'd1);

        // Test 6: cascade 00:10 counting down to 00 then wrap to 59
        en     = 1'b0;
        up     = 1'b0;
        load   = 1'b1;
        data   = 4'd0;
        t_data = 4'd1;
        @(negedge clk); #1;
        chk("cas_load_u", 32'(u_count), 32'd0);
        chk("cas_load_t", 32'(t_count), 32'd1);
        load = 1'b0;
        en   = 1'b1;
        t_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_u = (i == 0) ? 0 : ((i <= 10) ? 10 - i : 9);
            exp_t = (i == 0) ? 1 : ((i <= 10) ? 0 : 5);
            #1;
            chk("cas_units", 32'(u_count), 32'(exp_u));
            chk("cas_tens",  32'(t_count), 32'(exp_t));
            chk("cas_u_tc",  32'(u_tc), (i == 0 || i == 10) ? 32'd1 : 32'd0);
            chk("cas_t_tc",  32'(t_tc), (i == 10) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
